// File: rtl/fb_pkg.sv
// Shared types and constants for the projector framebuffer read path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_PIX_W  = 9;

    // Owner of a read slot travelling alongside the BRAM access
    typedef enum logic [1:0] {
        FB_TAG_NONE = 2'd0,
        FB_TAG_A    = 2'd1,
        FB_TAG_B    = 2'd2
    } fb_tag_t;

    // Arbiter mode: normal fixed priority, or B temporarily promoted
    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_FORCE_B = 1'b1
    } fb_arb_state_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Shift register carrying one read-owner tag per cycle, matched to the BRAM return path.
// Latency: DEPTH cycles from tag_in to tag_out.
// Backpressure: none; advances every cycle, reset flushes every stage to NONE.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  fb_tag_t tag_in,
    output fb_tag_t tag_out
);

    fb_tag_t stage [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= FB_TAG_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Two-client arbiter for the framebuffer read port (A = galvo, B = display); FB_ARB_STARVE_GUARD_EN adds B starvation guard.
// Latency: grant same cycle, mem_addr next cycle, rvalid/rdata RD_LATENCY+1 cycles after acceptance.
// Backpressure: requesters hold req/addr until granted; returns cannot be stalled.
module fb_read_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int PIX_W      = FB_PIX_W,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [PIX_W-1:0]  rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_dout
);

    // Reject configurations outside the supported range at elaboration
    if (RD_LATENCY < 1 || RD_LATENCY > 4 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_param_check
        $error("fb_read_arbiter: RD_LATENCY or STARVE_MAX out of range");
    end

    logic    prio_b;
    fb_tag_t tag_in;
    fb_tag_t tag_out;

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    fb_arb_state_t state;
    logic [7:0]    starve_cnt;
    logic [7:0]    starve_inc;

    assign starve_inc = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
    assign prio_b     = (state == ARB_FORCE_B);

    // Count denied B cycles; promote B once the limit is reached, demote after it is served or gives up
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_NORMAL;
            starve_cnt <= 8'd0;
        end else begin
            case (state)
                ARB_NORMAL: begin
                    if (gnt_b) begin
                        starve_cnt <= 8'd0;
                    end else if (req_b) begin
                        starve_cnt <= starve_inc;
                        if (starve_inc >= STARVE_LIM) begin
                            state <= ARB_FORCE_B;
                        end
                    end
                end
                ARB_FORCE_B: begin
                    if (gnt_b || !req_b) begin
                        state      <= ARB_NORMAL;
                        starve_cnt <= 8'd0;
                    end else begin
                        starve_cnt <= starve_inc;
                    end
                end
                default: begin
                    state      <= ARB_NORMAL;
                    starve_cnt <= 8'd0;
                end
            endcase
        end
    end
`else
    // Strict fixed priority: A always beats B
    assign prio_b = 1'b0;
`endif

    // Grants are mutually exclusive and forced low while reset is held
    assign gnt_a = reset_n & req_a & ~(prio_b & req_b);
    assign gnt_b = reset_n & req_b & (prio_b | ~req_a);

    // Capture the winner's address on the transfer edge, hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= '0;
        end else if (gnt_a) begin
            mem_addr <= addr_a;
        end else if (gnt_b) begin
            mem_addr <= addr_b;
        end
    end

    // Tag the slot with its owner so the return can be steered back
    always_comb begin
        tag_in = FB_TAG_NONE;
        if (gnt_a) begin
            tag_in = FB_TAG_A;
        end else if (gnt_b) begin
            tag_in = FB_TAG_B;
        end
    end

    // One stage for the address register plus RD_LATENCY for the BRAM
    fb_rd_tag_pipe #(
        .DEPTH (RD_LATENCY + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign rvalid_a = (tag_out == FB_TAG_A);
    assign rvalid_b = (tag_out == FB_TAG_B);
    assign rdata    = mem_dout;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Bench for fb_read_arbiter: two instances (RD_LATENCY 1 and 3) share one directed stimulus stream.
// Stimulus pushes expected returns into per-instance queues; a monitor pops and checks on every rvalid.
// Grants, mem_addr and reset behaviour are checked directly against hand-computed values.
module tb_fb_read_arbiter;
    import fb_pkg::*;

    typedef struct {
        fb_tag_t    tag;
        logic [8:0] dat;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_a, req_b;
    logic [15:0] addr_a, addr_b;

    logic        gnt_a1, gnt_b1, rvalid_a1, rvalid_b1;
    logic [8:0]  rdata1, mem_dout1;
    logic [15:0] mem_addr1;
    logic        gnt_a3, gnt_b3, rvalid_a3, rvalid_b3;
    logic [8:0]  rdata3, mem_dout3;
    logic [15:0] mem_addr3;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel contents of the framebuffer model
    function automatic logic [8:0] pix_of(input logic [15:0] a);
        if (a == 16'h1234) return 9'h1A5;
        return a[8:0] ^ a[15:7];
    endfunction

    // BRAM models: address sampled on the edge, data after RD_LATENCY edges
    logic [15:0] bram1_q;
    logic [15:0] bram3_q [3];
    always @(posedge clk) begin
        bram1_q    <= mem_addr1;
        bram3_q[0] <= mem_addr3;
        bram3_q[1] <= bram3_q[0];
        bram3_q[2] <= bram3_q[1];
    end
    assign mem_dout1 = pix_of(bram1_q);
    assign mem_dout3 = pix_of(bram3_q[2]);

    fb_read_arbiter #(.ADDR_W(16), .PIX_W(9), .RD_LATENCY(1), .STARVE_MAX(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a1), .rvalid_a(rvalid_a1),
        .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b1), .rvalid_b(rvalid_b1),
        .rdata(rdata1), .mem_addr(mem_addr1), .mem_dout(mem_dout1)
    );

    fb_read_arbiter #(.ADDR_W(16), .PIX_W(9), .RD_LATENCY(3), .STARVE_MAX(8)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a3), .rvalid_a(rvalid_a3),
        .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b3), .rvalid_b(rvalid_b3),
        .rdata(rdata3), .mem_addr(mem_addr3), .mem_dout(mem_dout3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input fb_tag_t tag, input logic [15:0] a);
        q1.push_back('{tag, pix_of(a), cyc + 2});
        q3.push_back('{tag, pix_of(a), cyc + 4});
    endtask

    // One cycle of stimulus: entered just after a rising edge, leaves just after the next
    task automatic drive(input logic ra, input logic [15:0] aa, input logic rb, input logic [15:0] ab,
                         input logic ea, input logic eb, input string nm);
        req_a  = ra;
        addr_a = aa;
        req_b  = rb;
        addr_b = ab;
        @(negedge clk);
        chk({nm, "_gnt_a_L1"}, gnt_a1, ea);
        chk({nm, "_gnt_b_L1"}, gnt_b1, eb);
        chk({nm, "_gnt_a_L3"}, gnt_a3, ea);
        chk({nm, "_gnt_b_L3"}, gnt_b3, eb);
        if (ea) push(FB_TAG_A, aa);
        else if (eb) push(FB_TAG_B, ab);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, "idle");
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_gnt_a_L1"}, gnt_a1, 1'b0);
        chk({nm, "_gnt_b_L1"}, gnt_b1, 1'b0);
        chk({nm, "_gnt_a_L3"}, gnt_a3, 1'b0);
        chk({nm, "_gnt_b_L3"}, gnt_b3, 1'b0);
        chk({nm, "_rvalid_L1"}, {rvalid_a1, rvalid_b1}, 2'b00);
        chk({nm, "_rvalid_L3"}, {rvalid_a3, rvalid_b3}, 2'b00);
        chk({nm, "_mem_addr_L1"}, mem_addr1, 16'h0000);
        chk({nm, "_mem_addr_L3"}, mem_addr3, 16'h0000);
    endtask

    // Scoreboard check of one return port
    task automatic mon(input int which, input logic va, input logic vb, input logic [8:0] rd);
        exp_t e;
        int   n;
        if (!(va || vb)) return;
        chk($sformatf("L%0d_ret_onehot", which), {31'b0, va & vb}, 32'd0);
        n = (which == 1) ? q1.size() : q3.size();
        if (n == 0) begin
            chk($sformatf("L%0d_ret_unexpected", which), {va, vb}, 2'b00);
            return;
        end
        if (which == 1) e = q1.pop_front();
        else e = q3.pop_front();
        chk($sformatf("L%0d_ret_tag", which), va ? FB_TAG_A : FB_TAG_B, e.tag);
        chk($sformatf("L%0d_ret_data", which), rd, e.dat);
        chk($sformatf("L%0d_ret_cycle", which), cyc, e.due);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(1, rvalid_a1, rvalid_b1, rdata1);
            mon(3, rvalid_a3, rvalid_b3, rdata3);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        eb;
        logic [15:0] a;
        reset_n = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        addr_a  = '0;
        addr_b  = '0;

        // Reset state, with both requests raised to prove grants are suppressed
        repeat (2) @(posedge clk);
        #1;
        req_a = 1'b1;
        req_b = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        idle(2);

        // Single A read: data 0x1A5 two cycles after acceptance (four for L3)
        drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b0, "singleA");
        chk("singleA_mem_addr_L1", mem_addr1, 16'h1234);
        chk("singleA_mem_addr_L3", mem_addr3, 16'h1234);
        idle(5);

        // Simultaneous requests: A first, B next cycle, returns in order
        drive(1'b1, 16'h0A00, 1'b1, 16'h0B00, 1'b1, 1'b0, "simul_c1");
        chk("simul_mem_addr_a", mem_addr1, 16'h0A00);
        drive(1'b0, 16'h0000, 1'b1, 16'h0B00, 1'b0, 1'b1, "simul_c2");
        chk("simul_mem_addr_b", mem_addr1, 16'h0B00);
        idle(5);

        // Both held for 30 cycles
        for (int i = 1; i <= 30; i++) begin
`ifdef FB_ARB_STARVE_GUARD_EN
            eb = (i % 9 == 0);
`else
            eb = 1'b0;
`endif
            drive(1'b1, 16'h1000 + 16'(i), 1'b1, 16'h2000 + 16'(i), !eb, eb, $sformatf("starve%0d", i));
        end
        drive(1'b0, 16'h0000, 1'b1, 16'h2FFF, 1'b0, 1'b1, "starve_release");
        idle(5);

        // Eight contended cycles (guard build ends up promoting B), last A read at 0x0010, then reset
        for (int i = 1; i <= 8; i++) begin
            a = (i == 8) ? 16'h0010 : 16'h3000 + 16'(i);
            drive(1'b1, a, 1'b1, 16'h3100, 1'b1, 1'b0, "rst_pre");
        end
        reset_n = 1'b0;
        q1.delete();
        q3.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_mid");
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        @(negedge clk);
        chk("rst_release_mem_addr_L1", mem_addr1, 16'h0000);
        chk("rst_release_mem_addr_L3", mem_addr3, 16'h0000);
        @(posedge clk);
        #1;
        idle(6);
        // State must be back to normal priority: A wins the contended cycle
        drive(1'b1, 16'h0020, 1'b1, 16'h0021, 1'b1, 1'b0, "post_rst_c1");
        drive(1'b0, 16'h0000, 1'b1, 16'h0021, 1'b0, 1'b1, "post_rst_c2");
        idle(5);

        // Back-to-back single-requester traffic, 100 transfers
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                drive(1'b0, 16'h0000, 1'b1, a, 1'b0, 1'b1, "sweep");
            else
                drive(1'b1, a, 1'b0, 16'h0000, 1'b1, 1'b0, "sweep");
        end
        idle(8);

        chk("drain_L1", q1.size(), 32'd0);
        chk("drain_L3", q3.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

- Shares the single read port of the projector framebuffer (64K × 9-bit pixel BRAM, 1-cycle read) between two requesters.
- Port A is the laser galvo scan engine, the latency-critical high-priority client. Port B is the debug/VGA display reader.
- Sits between both requesters and the framebuffer port-B pins (address out, pixel in). Runs in the read clock domain.
- Routes each returned pixel to the requester that issued the address.

## Interface

- `ADDR_W`, 16: framebuffer address width.
- `PIX_W`, 9: pixel width (RGB 3:3:3).
- `RD_LATENCY`, 1: cycles from `mem_addr` sampled by the BRAM to valid `mem_dout`. Legal range 1–4.
- `STARVE_MAX`, 8: consecutive denied cycles before port B is forced. Legal range 1–255.
- `clk` in 1: read clock. All logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_a` in 1: port A read request.
- `addr_a` in ADDR_W: port A address. Held while `req_a` is high and not granted.
- `gnt_a` out 1: port A accepted this cycle. Combinational from state and requests.
- `rvalid_a` out 1: `rdata` belongs to port A this cycle.
- `req_b` in 1: port B read request.
- `addr_b` in ADDR_W: port B address.
- `gnt_b` out 1: port B accepted this cycle.
- `rvalid_b` out 1: `rdata` belongs to port B this cycle.
- `rdata` out PIX_W: returned pixel, shared by both ports.
- `mem_addr` out ADDR_W: framebuffer read address (registered).
- `mem_dout` in PIX_W: framebuffer read data.

## Operation

- **Transfer.** A transfer occurs at a rising edge where `req_x && gnt_x`. At most one grant per cycle; `gnt_a` and `gnt_b` are never both high.
- **Grant.** At most one grant per cycle, decided by a two-state FSM:
  - NORMAL: A wins whenever `req_a` is high; otherwise B wins if `req_b` is high.
  - FORCE_B: B wins if `req_b` is high; otherwise A wins if `req_a` is high.
- **Starvation counter** (8 bits):
  - Increments on each cycle with `req_b && !gnt_b`, saturating at 255.
  - Clears on every B transfer.
- **FSM transitions:**
  - NORMAL → FORCE_B on the edge where the counter reaches `STARVE_MAX`.
  - FORCE_B → NORMAL on a B transfer, or on any edge where `req_b` is low; the counter also clears in that case.
- **Address register.** `mem_addr` loads the winner's address on the transfer edge. It holds its value when there is no transfer.
- **Tag pipeline.** A pipeline of depth `RD_LATENCY + 1` carries a tag {NONE, A, B} per cycle.
  - The pipeline output drives `rvalid_a`/`rvalid_b`.
  - `rdata` is `mem_dout` passed through combinationally. It is meaningful only while a `rvalid_x` is high.
- **Throughput.** Back-to-back transfers are allowed, one per cycle, to either port. There is no limit on outstanding reads.
- **Reset values.**
  - `gnt_a`/`gnt_b` are 0 while in reset.
  - `rvalid_a`/`rvalid_b` = 0, `mem_addr` = 0.
  - FSM = NORMAL, counter = 0, all tags = NONE.
  - The `rdata` value is don't-care.
- **Reset mid-operation.** Reads in flight are dropped: no `rvalid` is issued after reset deasserts. Requesters must reissue them.

## Timing

- Acceptance at edge E0 → `mem_addr` valid in the cycle after E0.
- `rvalid_x`/`rdata` are valid in the cycle after edge E0 + `RD_LATENCY`. Total latency is `RD_LATENCY + 1` cycles, which is 2 cycles by default.
- Latency is fixed and identical for both ports. Returns are in acceptance order.
- Grant is combinational: `req_x` → `gnt_x` in the same cycle, with no registered grant delay.
- With `req_a` held continuously in NORMAL, B is served once every `STARVE_MAX + 1` cycles when the starvation guard is enabled. Without the guard, B is never served.

## Configuration

- `FB_ARB_STARVE_GUARD_EN` defined: the starvation counter and FORCE_B state are compiled in, as described above.
- Macro undefined:
  - Counter and FSM are removed; strict fixed priority applies (A always beats B).
  - `STARVE_MAX` is ignored.
  - B can starve indefinitely.

## Structure

- Package `fb_pkg` holds:
  - Constants `FB_ADDR_W` = 16 and `FB_PIX_W` = 9.
  - Tag enum `fb_tag_t` {`FB_TAG_NONE`, `FB_TAG_A`, `FB_TAG_B`}, 2 bits.
  - Arbiter FSM enum `fb_arb_state_t` {`ARB_NORMAL`, `ARB_FORCE_B`}.
- Sub-module `fb_rd_tag_pipe`: parameterised-depth shift register of `fb_tag_t` with async reset to `FB_TAG_NONE`. It is instantiated once.
- Grant logic, counter, FSM and address register stay in the top module.

## Test plan

- **Single A read.** `req_a` = 1 one cycle, `addr_a` = 0x1234, BRAM model returns 0x1A5 → `gnt_a` same cycle, `mem_addr` = 0x1234 next cycle, `rvalid_a` = 1 with `rdata` = 0x1A5 exactly 2 cycles after acceptance, `rvalid_b` stays 0.
- **Simultaneous requests, NORMAL.** `req_a` = `req_b` = 1 for one cycle → `gnt_a` = 1, `gnt_b` = 0; B granted the following cycle; returns tagged A then B on consecutive cycles.
- **Starvation (macro on, STARVE_MAX = 8).** `req_a` and `req_b` held high for 30 cycles → B granted on cycles 9, 18 and 27; all other cycles grant A; counter returns to 0 after each B grant.
- **Strict priority (macro off).** Same stimulus as the starvation test → zero B grants over 30 cycles; B granted in the first cycle `req_a` drops.
- **Reset mid-flight.** Accept A read at 0x0010, assert `reset_n` = 0 the next cycle for 2 cycles → no `rvalid_a`/`rvalid_b` after release, `mem_addr` = 0, FSM = NORMAL.
- **RD_LATENCY = 3 sweep.** 100 random back-to-back mixed requests → every return arrives 4 cycles after its acceptance, with the correct port tag and address-derived data, in order.
